// File: rtl/ascii_uart_tx.sv
// Serialises a latched 6-character ASCII decimal word over an 8N1 UART line, MS char first, optional CR/LF.
// Latency: txd falls 1 cycle after start is sampled; busy lasts N*10*CLKS_PER_BIT cycles (N = chars sent).
// Backpressure: start is accepted only while busy=0 (including the done cycle); otherwise it is ignored.
//
// Ports:
//   clk            system clock, rising edge
//   reset          synchronous, active-high; aborts any transfer without a done pulse
//   start          transfer request, sampled only while busy=0
//   ascii_in       six ASCII chars, char0=[47:40] (MS digit) .. char5=[7:0] (LS digit)
//   suppress_zeros sampled with start; 1 = skip leading 0x30 chars (char5 always sent)
//   busy           high from the cycle after acceptance until the last stop bit ends
//   done           one-cycle pulse at completion
//   txd            registered UART serial output, idle high
module ascii_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter bit SEND_CRLF    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [47:0] ascii_in,
   input  logic        suppress_zeros,
   output logic        busy,
   output logic        done,
   output logic        txd
);

   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START_BIT = 2'd1,
      DATA_BITS = 2'd2,
      STOP_BIT  = 2'd3
   } state_t;

   state_t          state;
   logic [47:0]     word_q;
   logic [2:0]      char_idx;    // digit index 0..5, never wraps
   logic [1:0]      tail_cnt;    // 0 = digits, 1 = CR, 2 = LF
   logic [BW-1:0]   baud_cnt;
   logic [2:0]      bit_cnt;

   logic [2:0]      first_idx;
   logic [7:0]      cur_char;
   logic            baud_end;
   logic            last_char;

   // suppress_zeros only matters for the starting index, so it is folded into
   // char_idx at acceptance rather than stored separately.
   always_comb begin
      first_idx = 3'd5;
      if (!suppress_zeros)                 first_idx = 3'd0;
      else if (ascii_in[47:40] != 8'h30)   first_idx = 3'd0;
      else if (ascii_in[39:32] != 8'h30)   first_idx = 3'd1;
      else if (ascii_in[31:24] != 8'h30)   first_idx = 3'd2;
      else if (ascii_in[23:16] != 8'h30)   first_idx = 3'd3;
      else if (ascii_in[15:8]  != 8'h30)   first_idx = 3'd4;
   end

   always_comb begin
      cur_char = 8'h0A;
      if (tail_cnt == 2'd0) begin
         case (char_idx)
            3'd0:    cur_char = word_q[47:40];
            3'd1:    cur_char = word_q[39:32];
            3'd2:    cur_char = word_q[31:24];
            3'd3:    cur_char = word_q[23:16];
            3'd4:    cur_char = word_q[15:8];
            default: cur_char = word_q[7:0];
         endcase
      end else if (tail_cnt == 2'd1) begin
         cur_char = 8'h0D;
      end
   end

   assign baud_end  = (baud_cnt == BAUD_LAST);
   // Without CR/LF the tail counter never leaves 0, so the last char is digit 5.
   assign last_char = SEND_CRLF ? (tail_cnt == 2'd2) : (char_idx == 3'd5);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         word_q   <= '0;
         char_idx <= '0;
         tail_cnt <= '0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         txd      <= 1'b1;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  word_q   <= ascii_in;
                  char_idx <= first_idx;
                  tail_cnt <= 2'd0;
                  baud_cnt <= '0;
                  busy     <= 1'b1;
                  txd      <= 1'b0;
                  state    <= START_BIT;
               end
            end

            START_BIT: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  bit_cnt  <= 3'd0;
                  txd      <= cur_char[0];
                  state    <= DATA_BITS;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end

            DATA_BITS: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (bit_cnt == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP_BIT;
                  end else begin
                     bit_cnt <= bit_cnt + 3'd1;
                     txd     <= cur_char[bit_cnt + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end

            STOP_BIT: begin
               if (baud_end) begin
                  baud_cnt <= '0;
                  if (last_char) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     // Next char starts immediately: no idle gap between frames.
                     if (tail_cnt == 2'd0 && char_idx != 3'd5) char_idx <= char_idx + 3'd1;
                     else                                       tail_cnt <= tail_cnt + 2'd1;
                     txd   <= 1'b0;
                     state <= START_BIT;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_ONE;
               end
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule
